// File: rtl/pattern_loader.sv
// Host-word loader that fills the pattern RAM and variable RAM and drives the output controller.
// Optional build macro: LOADER_CHECKSUM_EN adds a running 16-bit sum of the pattern words.
module pattern_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        ram_we,
    output logic [11:0] ram_waddr,
    output logic [31:0] ram_wdata,
    output logic        var_we,
    output logic [3:0]  var_waddr,
    output logic [31:0] var_wdata,
    input  logic        active_buffer,
    input  logic        preload,
    input  logic        active,
    output logic        ready,
    output logic        switch,
    output logic        start,
    output logic        stop,
    output logic [1:0]  sync,
    output logic        err,
    output logic [15:0] checksum
);

    typedef enum logic [2:0] {StHdr, StPatHi, StPatLo, StVarHi, StVarLo} state_e;

    state_e      state_q;
    logic        rdy_q;
    logic        preload_q;
    logic        active_q;
    logic        base_hi_q;
    logic [11:0] cnt_q;
    logic [10:0] idx_q;
    logic [15:0] hi_q;

    logic [3:0]  opcode;
    logic [11:0] arg;
    logic        hdr_stall;
    logic        xfer;
    logic [11:0] idx_next;
    logic        pat_last;

    assign opcode = rx_data[15:12];
    assign arg    = rx_data[11:0];

    // A load header may not start while a buffer switch is still pending.
    assign hdr_stall = (state_q == StHdr) && switch && rx_valid &&
                       (opcode == 4'h1 || opcode == 4'h2);
    assign rx_ready  = rdy_q && !hdr_stall;
    assign xfer      = rx_valid && rx_ready;
    assign idx_next  = {1'b0, idx_q} + 12'd1;
    assign pat_last  = (idx_next == cnt_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StHdr;
            rdy_q     <= 1'b0;
            preload_q <= 1'b0;
            active_q  <= 1'b0;
            base_hi_q <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            hi_q      <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            var_we    <= 1'b0;
            var_waddr <= '0;
            var_wdata <= '0;
            ready     <= 1'b0;
            switch    <= 1'b0;
            start     <= 1'b0;
            stop      <= 1'b0;
            sync      <= '0;
            err       <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            var_we    <= 1'b0;
            rdy_q     <= 1'b1;
            preload_q <= preload;
            active_q  <= active;

            if (preload && !preload_q) switch <= 1'b0;

            // Controller has been idle across a whole cycle: the stop request is complete.
            if (stop && !active && !active_q) begin
                stop   <= 1'b0;
                start  <= 1'b0;
                ready  <= 1'b0;
                switch <= 1'b0;
            end

            if (xfer) begin
                unique case (state_q)
                    StHdr: begin
                        case (opcode)
                            4'h0: ;
                            4'h1: begin
                                if (arg == 12'd0 || arg > 12'd2048) begin
                                    err <= 1'b1;
                                end else begin
                                    cnt_q     <= arg;
                                    idx_q     <= '0;
                                    base_hi_q <= !active_buffer;
                                    state_q   <= StPatHi;
                                end
                            end
                            4'h2: begin
                                var_waddr <= arg[3:0];
                                state_q   <= StVarHi;
                            end
                            4'h3: begin
                                if (!active)     ready  <= 1'b1;
                                else if (switch) err    <= 1'b1;
                                else             switch <= 1'b1;
                            end
                            4'h4: begin
                                sync  <= arg[1:0];
                                start <= 1'b1;
                            end
                            4'h5:    stop <= 1'b1;
                            default: err  <= 1'b1;
                        endcase
                    end
                    StPatHi: begin
                        hi_q    <= rx_data;
                        state_q <= StPatLo;
                    end
                    StPatLo: begin
                        ram_we    <= 1'b1;
                        ram_waddr <= {base_hi_q, idx_q};
                        ram_wdata <= {hi_q, rx_data};
                        rdy_q     <= 1'b0;
                        idx_q     <= idx_next[10:0];
                        state_q   <= pat_last ? StHdr : StPatHi;
                    end
                    StVarHi: begin
                        hi_q    <= rx_data;
                        state_q <= StVarLo;
                    end
                    StVarLo: begin
                        var_we    <= 1'b1;
                        var_wdata <= {hi_q, rx_data};
                        rdy_q     <= 1'b0;
                        state_q   <= StHdr;
                    end
                    default: state_q <= StHdr;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum <= '0;
        end else if (xfer) begin
            if (state_q == StHdr && opcode == 4'h1) checksum <= '0;
            else if (state_q == StPatHi || state_q == StPatLo) checksum <= checksum + rx_data;
        end
    end
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: doc/pattern_loader.md
PATTERN_LOADER -- requirements
Module: pattern_loader

Interface
REQ-001 SHALL have: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have: reset  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: rx_data  in  16  host command/data word.
REQ-004 SHALL have: rx_valid  in  1 and rx_ready  out  1  host word handshake; a word transfers on a clk edge with both high.
REQ-005 SHALL have: ram_we  out  1, ram_waddr  out  12, ram_wdata  out  32  pattern RAM write port; an entry is {state_count[31:16], out_port[15:0]}.
REQ-006 SHALL have: var_we  out  1, var_waddr  out  4, var_wdata  out  32  variable RAM write port; an entry is {clock div[31:16], mode_count[15:0]}.
REQ-007 SHALL have: active_buffer  in  1, preload  in  1, active  in  1  status from the output controller, sampled on clk.
REQ-008 SHALL have: ready  out  1, switch  out  1, start  out  1, stop  out  1, sync  out  2  control to the output controller.
REQ-009 SHALL have: err  out  1  sticky protocol error, and checksum  out  16 (see Configuration).

Function
REQ-010 SHALL decode the header word as opcode = rx_data[15:12] and arg = rx_data[11:0].
REQ-011 SHALL implement states HDR, PAT_HI, PAT_LO, VAR_HI, VAR_LO; reset enters HDR.
REQ-012 Opcode 0x1 LOAD_PAT SHALL set count = arg and enter PAT_HI; arg 0 or arg > 2048 SHALL set err and stay in HDR.
REQ-013 PAT_HI SHALL latch the word as entry[31:16]; PAT_LO SHALL supply entry[15:0] and pulse ram_we for 1 cycle in the same cycle as the PAT_LO transfer, registered (write visible 1 cycle after the transfer).
REQ-014 Pattern base SHALL be latched at the LOAD_PAT header as active_buffer ? 0 : 2048; ram_waddr = base + index, index 0..count-1, no wrap beyond base+2047.
REQ-015 After the last PAT_LO, the FSM SHALL return to HDR; otherwise to PAT_HI.
REQ-016 Opcode 0x2 LOAD_VAR SHALL latch var_waddr = arg[3:0], then take VAR_HI/VAR_LO like PAT_HI/PAT_LO and pulse var_we once.
REQ-017 Opcode 0x3 COMMIT: if active = 0, SHALL set ready = 1; if active = 1, SHALL set switch = 1.
REQ-018 switch SHALL clear on the first clk with preload = 1 (rising edge detected on sampled preload).
REQ-019 While switch = 1, a LOAD_PAT or LOAD_VAR header SHALL be stalled (rx_ready = 0) until switch clears.
REQ-020 Opcode 0x4 START SHALL set sync = arg[1:0] and start = 1; opcode 0x5 STOP SHALL set stop = 1.
REQ-021 stop SHALL hold until the sampled active is 0 for a full clk cycle, then clear stop, start, ready, switch in the same cycle.
REQ-022 rx_ready SHALL be 1 in every state except the REQ-019 stall and the cycle of a ram_we/var_we pulse.
REQ-023 Opcodes 0x0 SHALL be no-op; 0x6-0xF SHALL set err and be ignored; err clears only on reset.
REQ-024 A COMMIT while active = 1 and switch already 1 SHALL set err and not change switch.

Reset
REQ-025 On reset low at a clk edge: state = HDR, rx_ready = 0, ram_we = 0, var_we = 0, ram_waddr = 0, var_waddr = 0, wdata = 0, ready = 0, switch = 0, start = 0, stop = 0, sync = 0, err = 0, checksum = 0; rx_ready = 1 the cycle after reset releases.
REQ-026 Reset mid-load SHALL abandon the transfer; no further write pulses occur.

Configuration
REQ-027 With LOADER_CHECKSUM_EN defined, checksum SHALL be the 16-bit wrapping sum of all PAT_HI and PAT_LO words, cleared at each LOAD_PAT header; without it, checksum SHALL be constant 0 and no adder is built.

Verification
REQ-028 reset, active_buffer=1, send 0x1002, 0x0003, 0x00AA, 0x0001, 0x0055 -> writes addr 0 = 0x000300AA and addr 1 = 0x00010055; checksum = 0x0103 when enabled.
REQ-029 active=1, active_buffer=0, LOAD_PAT 1 entry -> ram_waddr = 2048; then COMMIT -> switch = 1; preload pulse -> switch = 0 next cycle.
REQ-030 switch = 1, send LOAD_PAT header -> rx_ready = 0 until preload pulse, then header accepted.
REQ-031 send 0x1000 then 0x1801 -> err = 1, no ram_we, FSM in HDR.
REQ-032 START 0x4003 -> start = 1, sync = 3; STOP 0x5000 with active = 1 -> stop holds; active -> 0 -> stop, start, ready = 0.
REQ-033 reset asserted after PAT_HI of a LOAD_PAT -> no ram_we; next LOAD_PAT starts cleanly at index 0.
